// File: rtl/step_dir_receiver_pkg.sv
// Shared types for the step/dir receive path: sign-magnitude step word and receiver FSM states.
// Combinational definitions only; no latency, no backpressure.
package step_pkg;

    typedef struct packed {
        logic        dir;
        logic [30:0] mag;
    } step_word_t;

    localparam logic [30:0] STEP_MAG_MAX = 31'h7FFFFFFF;
    localparam logic        STEP_DIR_NEG = 1'b1;

    typedef enum logic {
        RX_IDLE,
        RX_MOVING
    } rx_state_t;

endpackage

// File: rtl/step_dir_receiver_if.sv
// Pin-side inputs and register-file-side outputs of the step/dir receiver.
// master drives the pins and reads the results; slave is the receiver itself.
interface step_dir_receiver_if;
    logic        step_in;
    logic        dir_in;
    logic        enable_n;
    logic        clear;
    logic [31:0] step_count;
    logic [31:0] period;
    logic [31:0] speed;
    logic        moving;
    logic        dir_err;
    logic        ovf;

    modport master (
        output step_in, dir_in, enable_n, clear,
        input  step_count, period, speed, moving, dir_err, ovf
    );

    modport slave (
        input  step_in, dir_in, enable_n, clear,
        output step_count, period, speed, moving, dir_err, ovf
    );
endinterface

// File: rtl/step_dir_receiver_sync_filter.sv
// Pin synchroniser plus glitch filter; level moves SYNC_STAGES + FILTER_LEN cycles after a clean edge.
// No backpressure; a run of differing samples shorter than FILTER_LEN is discarded.
module sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   smp;

    assign smp = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (smp == filt) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt  <= smp;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/step_dir_receiver.sv
// Decodes STEP/DIR/ENABLE# pins into a sign-magnitude step count, step period and speed; count lags step_in by SYNC_STAGES+FILTER_LEN+1.
// No backpressure. STEP_DIR_RX_PERIOD_EN enables the period counter, period/speed outputs and timeout exit from MOVING.
import step_pkg::*;

module step_dir_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int DIR_SETUP   = 2,
    parameter int TIMEOUT     = 50000000
) (
    input logic          clk,
    input logic          rst,
    step_dir_receiver_if.slave bus
);
    localparam int DSW = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);

    if (SYNC_STAGES < 2 || FILTER_LEN < 1 || DIR_SETUP < 0 || TIMEOUT < 1) begin : g_bad_params
        $error("step_dir_receiver: illegal parameter value");
    end

    logic f_step, f_dir, f_en_n;

    sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_step (
        .clk(clk), .rst(rst), .raw(bus.step_in), .filt(f_step));
    sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_dir (
        .clk(clk), .rst(rst), .raw(bus.dir_in), .filt(f_dir));
    sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_en (
        .clk(clk), .rst(rst), .raw(bus.enable_n), .filt(f_en_n));

    logic           step_prev, dir_prev;
    logic [DSW-1:0] dsc_q, dir_stable;
    logic           step_edge, dir_short;
    logic [31:0]    cnt_q;
    logic           dir_err_q, ovf_q;
    step_word_t     base, cnt_nxt;
    logic           sat;
    rx_state_t      state_q, state_nxt;

    assign step_edge  = f_step & ~step_prev & ~f_en_n;
    // A dir flip visible this cycle means zero cycles of stability so far.
    assign dir_stable = (f_dir != dir_prev) ? '0 : dsc_q;
    assign dir_short  = dir_stable < DSW'(DIR_SETUP);

    // clear is folded in before the edge so a coincident edge counts from zero.
    always_comb begin
        base    = bus.clear ? '0 : step_word_t'(cnt_q);
        cnt_nxt = base;
        sat     = 1'b0;
        if (step_edge) begin
            if (f_dir == base.dir) begin
                if (base.mag == STEP_MAG_MAX) sat = 1'b1;
                else                          cnt_nxt.mag = base.mag + 31'd1;
            end else if (base.mag > 31'd1) begin
                cnt_nxt.mag = base.mag - 31'd1;
            end else if (base.mag == 31'd1) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt.dir = f_dir;
                cnt_nxt.mag = 31'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_prev <= 1'b0;
            dir_prev  <= 1'b0;
            dsc_q     <= '0;
            cnt_q     <= '0;
            dir_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            state_q   <= RX_IDLE;
        end else begin
            step_prev <= f_step;
            dir_prev  <= f_dir;
            if (dir_stable != DSW'(DIR_SETUP)) dsc_q <= dir_stable + DSW'(1);
            else                               dsc_q <= dir_stable;
            cnt_q     <= cnt_nxt;
            dir_err_q <= (dir_err_q & ~bus.clear) | (step_edge & dir_short);
            ovf_q     <= (ovf_q & ~bus.clear) | sat;
            state_q   <= state_nxt;
        end
    end

`ifdef STEP_DIR_RX_PERIOD_EN
    logic [31:0] pcnt_q, pcnt_nxt, period_q, period_nxt, speed_q;

    always_comb begin
        state_nxt  = state_q;
        pcnt_nxt   = pcnt_q;
        period_nxt = period_q;
        case (state_q)
            RX_IDLE: begin
                if (step_edge) begin
                    state_nxt = RX_MOVING;
                    pcnt_nxt  = 32'd1;
                end
            end
            RX_MOVING: begin
                if (f_en_n) begin
                    state_nxt  = RX_IDLE;
                    period_nxt = '0;
                end else if (step_edge) begin
                    period_nxt = pcnt_q;
                    pcnt_nxt   = 32'd1;
                end else if (pcnt_q == 32'(TIMEOUT)) begin
                    state_nxt  = RX_IDLE;
                    period_nxt = '0;
                end else if (pcnt_q != '1) begin
                    pcnt_nxt = pcnt_q + 32'd1;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q   <= '0;
            period_q <= '0;
            speed_q  <= '0;
        end else begin
            pcnt_q   <= pcnt_nxt;
            period_q <= period_nxt;
            speed_q  <= period_nxt >> 1;
        end
    end

    assign bus.period = period_q;
    assign bus.speed  = speed_q;
`else
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RX_IDLE:   if (step_edge) state_nxt = RX_MOVING;
            RX_MOVING: if (f_en_n)    state_nxt = RX_IDLE;
            default:   state_nxt = RX_IDLE;
        endcase
    end

    assign bus.period = '0;
    assign bus.speed  = '0;
`endif

    assign bus.step_count = cnt_q;
    assign bus.moving     = (state_q == RX_MOVING);
    assign bus.dir_err    = dir_err_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_step_dir_receiver.sv
// Directed plus randomized bench for step_dir_receiver against a signed-position model.
import step_pkg::*;

module tb_step_dir_receiver;
    localparam int    TMO  = 400;
    localparam longint MAXM = 64'h7FFFFFFF;
`ifdef STEP_DIR_RX_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     total = 0;
    int     bad = 0;
    longint pos = 0;
    bit     ovf_m = 1'b0;

    step_dir_receiver_if sif();

    step_dir_receiver #(.TIMEOUT(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(longint p);
        if (p < 0) return {STEP_DIR_NEG, 31'(-p)};
        return {1'b0, 31'(p)};
    endfunction

    function automatic logic [31:0] pv(int v);
        return PEN ? 32'(v) : 32'd0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(int h, int l);
        sif.step_in = 1'b1;
        cyc(h);
        sif.step_in = 1'b0;
        cyc(l);
    endtask

    // Model: signed position, magnitude clamped at 2^31-1.
    task automatic model_step(bit d);
        longint np;
        np = pos + (d ? -1 : 1);
        if (np > MAXM || np < -MAXM) ovf_m = 1'b1;
        else                         pos = np;
    endtask

    initial begin
        int h, l, prev;
        bit d;
        sif.step_in  = 1'b0;
        sif.dir_in   = 1'b0;
        sif.enable_n = 1'b0;
        sif.clear    = 1'b0;
        cyc(3);
        check("rst_count",   sif.step_count, 32'd0);
        check("rst_period",  sif.period,     32'd0);
        check("rst_moving",  32'(sif.moving), 32'd0);
        rst = 1'b0;
        cyc(10);

        // 1: ten 40-cycle steps, then timeout
        for (int i = 0; i < 10; i++) begin
            pulse(20, 20);
            model_step(1'b0);
            check("t1_count", sif.step_count, enc(pos));
        end
        check("t1_count_a", sif.step_count, 32'h0000000A);
        check("t1_period", sif.period, pv(40));
        check("t1_speed",  sif.speed,  pv(20));
        check("t1_moving", 32'(sif.moving), 32'd1);
        check("t1_dir_err", 32'(sif.dir_err), 32'd0);
        cyc(TMO - 60);
        check("t1_pre_tmo", 32'(sif.moving), 32'd1);
        cyc(100);
        check("t1_tmo_moving", 32'(sif.moving), PEN ? 32'd0 : 32'd1);
        check("t1_tmo_period", sif.period, 32'd0);
        sif.clear = 1'b1;
        cyc(1);
        sif.clear = 1'b0;
        pos = 0;
        cyc(1);
        check("clr_count", sif.step_count, 32'd0);

        // 2: crossing zero
        for (int i = 0; i < 3; i++) begin
            pulse(20, 20);
            model_step(1'b0);
            check("t2_fwd", sif.step_count, enc(pos));
        end
        sif.dir_in = 1'b1;
        cyc(10);
        for (int i = 0; i < 5; i++) begin
            pulse(20, 20);
            model_step(1'b1);
            check("t2_rev", sif.step_count, enc(pos));
        end
        check("t2_end", sif.step_count, 32'h80000002);
        check("t2_dir_err", 32'(sif.dir_err), 32'd0);

        // 3: dir flipped one cycle before the step rise
        cyc(10);
        sif.dir_in = 1'b0;
        cyc(1);
        pulse(20, 20);
        model_step(1'b0);
        check("t3_dir_err", 32'(sif.dir_err), 32'd1);
        check("t3_count", sif.step_count, enc(pos));
        sif.clear = 1'b1;
        cyc(1);
        sif.clear = 1'b0;
        pos = 0;
        cyc(1);
        check("t3_clr_err", 32'(sif.dir_err), 32'd0);
        check("t3_clr_count", sif.step_count, 32'd0);

        // clear in the same cycle as a counted edge
        pulse(20, 20);
        model_step(1'b0);
        pulse(20, 20);
        model_step(1'b0);
        sif.step_in = 1'b1;
        cyc(6);
        sif.clear = 1'b1;
        cyc(1);
        sif.clear = 1'b0;
        pos = 0;
        model_step(1'b0);
        cyc(13);
        sif.step_in = 1'b0;
        cyc(20);
        check("clr_edge", sif.step_count, enc(pos));

        // 4: glitch and disabled steps
        pulse(2, 20);
        check("t4_glitch", sif.step_count, enc(pos));
        sif.enable_n = 1'b1;
        cyc(10);
        check("t4_dis_moving", 32'(sif.moving), 32'd0);
        for (int i = 0; i < 5; i++) pulse(20, 20);
        check("t4_dis_count", sif.step_count, enc(pos));
        check("t4_dis_moving2", 32'(sif.moving), 32'd0);
        check("t4_dis_period", sif.period, 32'd0);
        sif.enable_n = 1'b0;
        cyc(20);

        // randomized step train
        prev = 0;
        for (int i = 0; i < 12; i++) begin
            d = 1'($urandom_range(0, 1));
            sif.dir_in = d;
            cyc(12);
            h = int'($urandom_range(6, 30));
            l = int'($urandom_range(12, 30));
            pulse(h, l);
            model_step(d);
            check("rnd_count",  sif.step_count, enc(pos));
            check("rnd_period", sif.period, pv(prev));
            check("rnd_speed",  sif.speed,  pv(prev / 2));
            prev = h + l + 12;
        end
        check("rnd_dir_err", 32'(sif.dir_err), 32'd0);

        // 5: saturation
        sif.dir_in = 1'b0;
        cyc(20);
        force dut.cnt_q = 32'h7FFFFFFE;
        cyc(1);
        release dut.cnt_q;
        pos = MAXM - 1;
        pulse(20, 20);
        model_step(1'b0);
        check("t5_first", sif.step_count, enc(pos));
        check("t5_no_ovf", 32'(sif.ovf), 32'(ovf_m));
        for (int i = 0; i < 2; i++) begin
            pulse(20, 20);
            model_step(1'b0);
        end
        check("t5_count", sif.step_count, 32'h7FFFFFFF);
        check("t5_ovf", 32'(sif.ovf), 32'(ovf_m));

        // 6: asynchronous reset mid-train
        pulse(20, 20);
        pulse(20, 20);
        sif.step_in = 1'b1;
        cyc(3);
        #2 rst = 1'b1;
        #1;
        check("t6_count",  sif.step_count, 32'd0);
        check("t6_moving", 32'(sif.moving), 32'd0);
        check("t6_period", sif.period, 32'd0);
        check("t6_speed",  sif.speed, 32'd0);
        check("t6_flags",  {30'd0, sif.dir_err, sif.ovf}, 32'd0);
        sif.step_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pos = 0;
        ovf_m = 1'b0;
        cyc(5);
        pulse(20, 20);
        model_step(1'b0);
        check("t6_moving2", 32'(sif.moving), 32'd1);
        check("t6_period2", sif.period, 32'd0);
        check("t6_count2",  sif.step_count, enc(pos));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/step_dir_receiver.md
Name: step_dir_receiver

Overview:
- Receive-side counterpart of the step/dir generators.
- Samples external STEP/DIR/ENABLE# pins (e.g. a loop-back of an axis driver, or a host step source) and decodes them into a step word in the axis sign-magnitude format (bit31 = dir, [30:0] = magnitude).
- Measures the step period and reports it in the same units as the generator speed word.
- Sits between the pin synchronisers and the HPS-visible register file.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on step_in/dir_in/enable_n (min 2).
- FILTER_LEN, 4, consecutive equal synchronised samples required before a filtered level changes (min 1).
- DIR_SETUP, 2, cycles filtered dir must be stable before a filtered step rising edge.
- TIMEOUT, 50000000, idle cycles after the last step edge before leaving MOVING.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- step_in  in  1  raw step pin; one step per rising edge
- dir_in  in  1  raw dir pin; 1 = negative (sets bit31)
- enable_n  in  1  raw active-low driver enable; steps are ignored while high
- clear  in  1  synchronous pulse; zeroes step_count and all sticky flags
- step_count  out  32  sign-magnitude accumulated steps, generator step-word format
- period  out  32  clk cycles between the last two counted rising edges
- speed  out  32  period >> 1, comparable to the generator speed word
- moving  out  1  high in MOVING state
- dir_err  out  1  sticky; a step edge occurred with dir stable fewer than DIR_SETUP cycles
- ovf  out  1  sticky; magnitude saturated

Behaviour:
- Reset (async, rst = 1): all outputs 0, filters hold 0, state IDLE, synchronisers 0.
- Input conditioning:
  - Each pin passes through SYNC_STAGES flops, then a filter.
  - The filtered level flips only after FILTER_LEN consecutive samples differ from it.
  - The filter counter restarts on any sample that matches the current filtered level.
- Edge detection:
  - A step_edge is a filtered step 0 -> 1 while filtered enable_n = 0.
  - Latency from a step_in rise to the step_count update is SYNC_STAGES + FILTER_LEN + 1 cycles.
  - Edges that arrive while enable_n is high are dropped and do not affect period or state.
- Dir setup:
  - A counter of cycles since the filtered dir last changed saturates at DIR_SETUP.
  - If it is below DIR_SETUP at a step_edge, set dir_err. The step is still counted using the current filtered dir.
- Count update on each step_edge (d = filtered dir, s = step_count[31], m = step_count[30:0]):
  - d == s and m < 31'h7FFFFFFF: m + 1.
  - d == s and m == 31'h7FFFFFFF: hold and set ovf.
  - d != s and m > 1: m - 1.
  - d != s and m == 1: becomes {0, 0}. Zero is always positive.
  - d != s and m == 0: becomes {d, 1}.
- FSM IDLE / MOVING:
  - IDLE -> MOVING on step_edge. The period counter is loaded with 1 and period is not updated.
  - In MOVING, the counter increments each cycle and saturates at 32'hFFFFFFFF.
  - On a step_edge in MOVING: period <= counter, then the counter reloads to 1.
  - MOVING -> IDLE when the counter reaches TIMEOUT, or when filtered enable_n goes high. On this transition period and speed are cleared to 0.
- clear:
  - step_count <= 0, dir_err <= 0, ovf <= 0. State and period are untouched.
  - If clear and step_edge occur in the same cycle, clear applies first and the edge is then counted, giving {d, 1}.
- A step_edge and the TIMEOUT expiry in the same cycle: the edge wins and the state stays MOVING.
- All outputs are registered.

Optional Feature:
- Macro: STEP_DIR_RX_PERIOD_EN.
- Defined: period counter, period, speed and TIMEOUT-based exit to IDLE are implemented as described above.
- Undefined:
  - No period counter is instantiated; period and speed are tied to 0.
  - moving is high while filtered enable_n = 0 and at least one edge has been seen since reset or enable assertion.
  - MOVING is left only on enable_n high.

Decomposition:
- Shared package step_pkg:
  - typedef step_word_t (32-bit sign-magnitude; fields dir and mag[30:0]).
  - Constants STEP_MAG_MAX = 31'h7FFFFFFF and STEP_DIR_NEG = 1'b1.
  - State enum rx_state_t {RX_IDLE, RX_MOVING}.
- One sub-module, sync_filter: SYNC_STAGES synchroniser plus FILTER_LEN glitch filter. It is instantiated three times (step, dir, enable_n).

Test Plan:
1. Default parameters; enable_n = 0, dir = 0; 10 step pulses, 20 cycles high / 20 cycles low -> step_count = 32'h0000000A, period = 40, speed = 20, moving = 1. TIMEOUT cycles after the last edge -> moving = 0, period = 0.
2. 3 steps with dir = 0, then dir = 1 held 10 cycles, then 5 steps -> step_count passes 3, 2, 1, 0, then ends at 32'h80000002. dir_err = 0.
3. Toggle dir 1 cycle before a step rise (after filtering) -> dir_err = 1 and the step is counted with the new dir. Pulse clear -> dir_err = 0, step_count = 0.
4. 2-cycle glitch on step_in (below FILTER_LEN) -> no count change. enable_n = 1 with 5 valid pulses -> step_count unchanged, moving = 0.
5. Force step_count near the limit via a bench backdoor to 32'h7FFFFFFE; 3 steps with dir = 0 -> step_count = 32'h7FFFFFFF, ovf = 1.
6. rst asserted mid-pulse train with moving = 1 -> all outputs 0 immediately (asynchronous). After release, the first edge moves the FSM to MOVING with period still 0.
